// File: rtl/video_window_place.sv
// Window placer: drops a FIFO-fed sub-image into the source-timed active frame, background elsewhere.
// Latency: vs/hs/de/data out exactly 2 pixclk_in cycles after the source timing.
// Backpressure: win_ready_o low when FIFO full; writes are also taken when full if a pop happens that cycle.
// Optional: define WIN_BORDER_EN to paint the 1-pixel window perimeter with BORDER_COLOR.
module video_window_place #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 720,
  parameter int CH         = 3,
  parameter int DW         = 8,
  parameter int CW         = 12,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic             pixclk_in,
  input  logic             rst_i,
  input  logic             vs_in,
  input  logic             hs_in,
  input  logic             de_in,
  input  logic             win_valid_i,
  input  logic [CH*DW-1:0] win_data_i,
  output logic             win_ready_o,
  input  logic [CW-1:0]    off_x_i,
  input  logic [CW-1:0]    off_y_i,
  input  logic [CW-1:0]    win_w_i,
  input  logic [CW-1:0]    win_h_i,
  input  logic [CH*DW-1:0] bg_color_i,
  input  logic [CH-1:0]    invert_i,
  input  logic             clr_status_i,
  output logic             vs_out,
  output logic             hs_out,
  output logic             de_out,
  output logic [CH*DW-1:0] data_out,
  output logic             underflow_o,
  output logic             overflow_o
);

  localparam int PW = CH * DW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   ONE_E    = {{CW{1'b0}}, 1'b1};
  localparam logic [CW:0]   H_LIM    = (CW+1)'(H_ACT);
  localparam logic [CW:0]   V_LIM    = (CW+1)'(V_ACT);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
`ifdef WIN_BORDER_EN
  localparam logic [PW-1:0] BORDER_COLOR = '1;
`endif

  // Edge detection and frame arming
  logic vs_prev, de_prev, armed;
  logic vs_rise, de_fall, active;
  assign vs_rise = vs_in & ~vs_prev;
  assign de_fall = de_prev & ~de_in;
  assign active  = armed | vs_rise;

  // Counters and shadow configuration
  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] sh_x, sh_y;
  logic [CW:0]   sh_w, sh_h;
  logic [PW-1:0] sh_bg;
  logic [CH-1:0] sh_inv;

  // FIFO state
  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          empty, full;
  assign empty = (occ == '0);
  assign full  = (occ == OCC_FULL);
  assign win_ready_o = ~rst_i & ~full;

  // Stage-1 and stage-2 registers
  logic          s1_vs, s1_hs, s1_de, s1_win;
  logic [PW-1:0] s1_dat;
  logic [PW-1:0] inv_mask, pix_nxt;

  // Clamp the incoming window size against the frame edge at latch time
  logic [CW:0] ox_e, oy_e, room_x, room_y, w_clamp, h_clamp;
  always_comb begin
    ox_e    = {1'b0, off_x_i};
    oy_e    = {1'b0, off_y_i};
    room_x  = H_LIM - ox_e;
    room_y  = V_LIM - oy_e;
    w_clamp = {1'b0, win_w_i};
    h_clamp = {1'b0, win_h_i};
    if (ox_e >= H_LIM)       w_clamp = '0;
    else if (w_clamp > room_x) w_clamp = room_x;
    if (oy_e >= V_LIM)       h_clamp = '0;
    else if (h_clamp > room_y) h_clamp = room_y;
  end

  // Window hit test in CW+1 bits so origin+size cannot wrap
  logic [CW:0] hx, vy, x0, y0, x_end, y_end;
  logic        in_win;
  assign hx    = {1'b0, h_cnt};
  assign vy    = {1'b0, v_cnt};
  assign x0    = {1'b0, sh_x};
  assign y0    = {1'b0, sh_y};
  assign x_end = x0 + sh_w;
  assign y_end = y0 + sh_h;
  assign in_win = de_in & active & (hx >= x0) & (hx < x_end) & (vy >= y0) & (vy < y_end);

  // FIFO handshake: flush on frame start beats any push/pop; empty+push bypasses the RAM
  logic pop_req, pop_ok, push_ok, bypass, wr_en, uf_set, of_set;
  assign pop_req = in_win & ~vs_rise;
  assign push_ok = win_valid_i & ~vs_rise & (~full | pop_req);
  assign pop_ok  = pop_req & ~empty;
  assign bypass  = pop_req & empty & push_ok;
  assign wr_en   = push_ok & ~bypass;
  assign uf_set  = pop_req & empty & ~push_ok;
  assign of_set  = win_valid_i & ~vs_rise & ~push_ok;

  // Edge history, arming and raster counters
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
      armed   <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      vs_prev <= vs_in;
      de_prev <= de_in;
      armed   <= armed | vs_rise;
      if (!de_in)               h_cnt <= '0;
      else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + CNT_ONE;
      if (vs_rise)                          v_cnt <= '0;
      else if (de_fall && v_cnt != CNT_MAX) v_cnt <= v_cnt + CNT_ONE;
    end
  end

  // Configuration shadow, only updated at frame start
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_w   <= '0;
      sh_h   <= '0;
      sh_bg  <= '0;
      sh_inv <= '0;
    end else if (vs_rise) begin
      sh_x   <= off_x_i;
      sh_y   <= off_y_i;
      sh_w   <= w_clamp;
      sh_h   <= h_clamp;
      sh_bg  <= bg_color_i;
      sh_inv <= invert_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (vs_rise) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop_ok})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage, no reset so it maps onto RAM
  always_ff @(posedge pixclk_in) begin
    if (wr_en) mem[wr_ptr] <= win_data_i;
  end

  // Sticky status; clear dominates a same-cycle set
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      underflow_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else if (clr_status_i) begin
      underflow_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (uf_set) underflow_o <= 1'b1;
      if (of_set) overflow_o  <= 1'b1;
    end
  end

`ifdef WIN_BORDER_EN
  logic on_edge, s1_bdr;
  assign on_edge = (hx == x0) | (hx == x_end - ONE_E) | (vy == y0) | (vy == y_end - ONE_E);
  // Perimeter flag travels with the pixel; the FIFO is still popped underneath it
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) s1_bdr <= 1'b0;
    else       s1_bdr <= pop_req & on_edge;
  end
`endif

  // Stage 1: delayed timing (gated until the first frame start) and popped pixel
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      s1_vs  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_de  <= 1'b0;
      s1_win <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vs  <= vs_in & active;
      s1_hs  <= hs_in & active;
      s1_de  <= de_in & active;
      s1_win <= pop_ok | bypass;
      s1_dat <= bypass ? win_data_i : mem[rd_ptr];
    end
  end

  // Output pixel select: blank, window (with invert), border or background
  always_comb begin
    inv_mask = '0;
    for (int c = 0; c < CH; c++) inv_mask[c*DW +: DW] = {DW{sh_inv[c]}};
    pix_nxt = sh_bg;
    if (!s1_de)      pix_nxt = '0;
    else if (s1_win) pix_nxt = s1_dat ^ inv_mask;
`ifdef WIN_BORDER_EN
    if (s1_de && s1_bdr) pix_nxt = BORDER_COLOR;
`endif
  end

  // Stage 2: registered outputs
  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      vs_out   <= 1'b0;
      hs_out   <= 1'b0;
      de_out   <= 1'b0;
      data_out <= '0;
    end else begin
      vs_out   <= s1_vs;
      hs_out   <= s1_hs;
      de_out   <= s1_de;
      data_out <= pix_nxt;
    end
  end

endmodule

// File: tb/tb_video_window_place.sv
module tb_video_window_place;

  logic        pixclk_in = 1'b0;
  logic        rst_i = 1'b0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic        win_valid_i = 1'b0;
  logic [23:0] win_data_i = '0;
  logic        win_ready_o;
  logic [11:0] off_x_i = '0, off_y_i = '0, win_w_i = '0, win_h_i = '0;
  logic [23:0] bg_color_i = '0;
  logic [2:0]  invert_i = '0;
  logic        clr_status_i = 1'b0;
  logic        vs_out, hs_out, de_out;
  logic [23:0] data_out;
  logic        underflow_o, overflow_o;

  video_window_place dut (
    .pixclk_in(pixclk_in), .rst_i(rst_i), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .win_valid_i(win_valid_i), .win_data_i(win_data_i), .win_ready_o(win_ready_o),
    .off_x_i(off_x_i), .off_y_i(off_y_i), .win_w_i(win_w_i), .win_h_i(win_h_i),
    .bg_color_i(bg_color_i), .invert_i(invert_i), .clr_status_i(clr_status_i),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .data_out(data_out),
    .underflow_o(underflow_o), .overflow_o(overflow_o)
  );

  always #5 pixclk_in = ~pixclk_in;

  typedef struct {
    int          fr;
    int          v;
    int          h;
    logic [23:0] exp;
  } vec_t;

  vec_t        tbl [22];
  logic [23:0] cap [4][16][640];
  int n_pass = 0, n_tot = 0;
  int cyc = 0;
  int feed_mode = 0, feed_idx = 0, raw_idx = 0;
  int cap_fr = 0, ov = 0, oh = 0, blank_bad = 0;
  int t_vs_in = -1, t_de_in = -1, t_vs_out = -1, t_de_out = -1;
  bit lat_arm = 0;
  logic vs_in_q = 0, de_in_q = 0, vs_out_q = 0, de_out_q = 0;

  function automatic logic [23:0] ramp(input int i);
    return 24'hA00000 + 24'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pixclk_in);
  endtask

  task automatic vsync(input int fr);
    tick(8);
    cap_fr = fr;
    vs_in = 1'b1;
    tick(3);
    vs_in = 1'b0;
    tick(4);
  endtask

  // One line: 120 blanking cycles (optionally pushing npush raw pixels), then 640 active
  task automatic line(input int npush);
    hs_in = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i == 10) hs_in = 1'b0;
      if (npush > 0) begin
        win_valid_i = (i < npush);
        if (i < npush) begin
          win_data_i = ramp(raw_idx);
          raw_idx++;
        end
      end
      tick(1);
    end
    de_in = 1'b1;
    tick(640);
    de_in = 1'b0;
  endtask

  // Input-side timestamps for latency measurement
  always @(posedge pixclk_in) begin
    if (lat_arm && vs_in && !vs_in_q && t_vs_in < 0) t_vs_in = cyc;
    if (lat_arm && de_in && !de_in_q && t_de_in < 0) t_de_in = cyc;
    vs_in_q = vs_in;
    de_in_q = de_in;
    cyc++;
  end

  // Output monitor: own raster position, frame capture, blanking rule
  always @(negedge pixclk_in) begin
    if (!de_out && data_out !== 24'h0) blank_bad++;
    if (lat_arm && vs_out && !vs_out_q && t_vs_out < 0) t_vs_out = cyc;
    if (lat_arm && de_out && !de_out_q && t_de_out < 0) t_de_out = cyc;
    if (vs_out && !vs_out_q) ov = 0;
    else if (de_out_q && !de_out) ov++;
    if (de_out) begin
      if (ov < 16 && oh < 640) cap[cap_fr][ov][oh] = data_out;
      oh++;
    end else oh = 0;
    vs_out_q = vs_out;
    de_out_q = de_out;
  end

  // Ready-respecting window feeder: mode 1 ramp, mode 2 constant 0x123456
  always @(negedge pixclk_in) begin
    if (feed_mode != 0) begin
      if (win_ready_o) begin
        win_valid_i = 1'b1;
        win_data_i  = (feed_mode == 1) ? ramp(feed_idx) : 24'h123456;
        feed_idx++;
      end else win_valid_i = 1'b0;
    end
  end

  initial begin
    // Frame 0: window 100x50 at (20,10), ramp data, bg 0x0000FF
    tbl[0]  = '{0, 10, 20,  ramp(0)};
    tbl[1]  = '{0, 10, 19,  24'h0000FF};
    tbl[2]  = '{0, 10, 119, ramp(99)};
    tbl[3]  = '{0, 10, 120, 24'h0000FF};
    tbl[4]  = '{0, 11, 20,  ramp(100)};
    tbl[5]  = '{0, 9,  20,  24'h0000FF};
    tbl[6]  = '{0, 11, 119, ramp(199)};
    tbl[7]  = '{0, 0,  0,   24'h0000FF};
    tbl[8]  = '{0, 10, 300, 24'h0000FF};
    // Frame 1: off_x now 300, invert ch0/ch2: 0x123456 -> ch2 ~12=ED, ch1 34, ch0 ~56=A9
    tbl[9]  = '{1, 10, 300, 24'hED34A9};
    tbl[10] = '{1, 11, 399, 24'hED34A9};
    tbl[11] = '{1, 10, 299, 24'h00FF00};
    tbl[12] = '{1, 10, 20,  24'h00FF00};
    tbl[13] = '{1, 10, 400, 24'h00FF00};
    // Frame 2: off_x 600, width 100 clamped to 40; 100 pushed per line, 40 popped
    tbl[14] = '{2, 0, 599, 24'h0F0F0F};
    tbl[15] = '{2, 0, 600, ramp(0)};
    tbl[16] = '{2, 0, 639, ramp(39)};
    tbl[17] = '{2, 1, 600, ramp(40)};
    tbl[18] = '{2, 1, 639, ramp(79)};
    // Frame 3: starved window shows background
    tbl[19] = '{3, 0, 0,  24'h000055};
    tbl[20] = '{3, 0, 9,  24'h000055};
    tbl[21] = '{3, 0, 10, 24'h000055};

    #1 rst_i = 1'b1;
    tick(3);
    chk("reset de_out", 32'(de_out), 32'h0);
    chk("reset vs_out", 32'(vs_out), 32'h0);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset win_ready_o", 32'(win_ready_o), 32'h0);
    chk("reset underflow_o", 32'(underflow_o), 32'h0);
    chk("reset overflow_o", 32'(overflow_o), 32'h0);
    rst_i = 1'b0;
    tick(1);
    chk("ready after reset", 32'(win_ready_o), 32'h1);

    // Fill FIFO with raw valid, one beyond capacity
    for (int i = 0; i < 1025; i++) begin
      win_valid_i = 1'b1;
      win_data_i  = ramp(i);
      tick(1);
    end
    win_valid_i = 1'b0;
    chk("full ready low", 32'(win_ready_o), 32'h0);
    chk("overflow on full", 32'(overflow_o), 32'h1);

    // Reset pulse in the middle of an active line
    bg_color_i = 24'h332211;
    vsync(3);
    hs_in = 1'b1; tick(5); hs_in = 1'b0;
    de_in = 1'b1;
    tick(20);
    chk("pre-reset de_out", 32'(de_out), 32'h1);
    chk("pre-reset pixel", 32'(data_out), 32'h332211);
    @(posedge pixclk_in);
    #2 rst_i = 1'b1;
    #1;
    chk("mid-reset de_out", 32'(de_out), 32'h0);
    chk("mid-reset data_out", 32'(data_out), 32'h0);
    chk("mid-reset ready", 32'(win_ready_o), 32'h0);
    chk("mid-reset overflow", 32'(overflow_o), 32'h0);
    @(negedge pixclk_in);
    rst_i = 1'b0;
    tick(1);
    chk("post-reset ready", 32'(win_ready_o), 32'h1);
    chk("post-reset underflow", 32'(underflow_o), 32'h0);
    tick(20);
    chk("no output before vsync", 32'(de_out), 32'h0);
    de_in = 1'b0;
    tick(5);

    // Frame 0
    off_x_i = 12'd20; off_y_i = 12'd10; win_w_i = 12'd100; win_h_i = 12'd50;
    bg_color_i = 24'h0000FF; invert_i = 3'b000;
    lat_arm = 1;
    vsync(0);
    feed_idx = 0; feed_mode = 1;
    for (int v = 0; v < 12; v++) begin
      if (v == 2) off_x_i = 12'd300;
      line(0);
    end
    feed_mode = 0; win_valid_i = 1'b0;
    lat_arm = 0;
    chk("frame0 no underflow", 32'(underflow_o), 32'h0);
    chk("vs latency", 32'(t_vs_out - t_vs_in), 32'd2);
    chk("de latency", 32'(t_de_out - t_de_in), 32'd2);

    // Frame 1: stale ramp data left in FIFO must be flushed at frame start
    bg_color_i = 24'h00FF00; invert_i = 3'b101;
    vsync(1);
    feed_idx = 0; feed_mode = 2;
    for (int v = 0; v < 12; v++) line(0);
    feed_mode = 0; win_valid_i = 1'b0;

    // Frame 2: clamped window, surplus accumulates until overflow
    bg_color_i = 24'h0F0F0F; invert_i = 3'b000;
    off_x_i = 12'd600; off_y_i = 12'd0; win_w_i = 12'd100; win_h_i = 12'd30;
    vsync(2);
    raw_idx = 0;
    for (int v = 0; v < 20; v++) begin
      line(100);
      if (v == 3) chk("no overflow early", 32'(overflow_o), 32'h0);
    end
    chk("overflow accumulates", 32'(overflow_o), 32'h1);
    clr_status_i = 1'b1;
    tick(1);
    clr_status_i = 1'b0;
    chk("overflow cleared", 32'(overflow_o), 32'h0);

    // Frame 3: starved window, clear held during the first pops
    bg_color_i = 24'h000055;
    off_x_i = 12'd0; off_y_i = 12'd0; win_w_i = 12'd10; win_h_i = 12'd1;
    vsync(3);
    tick(20);
    for (int i = 0; i < 640; i++) begin
      de_in = 1'b1;
      clr_status_i = (i < 6);
      if (i == 5)  chk("clear beats set", 32'(underflow_o), 32'h0);
      if (i == 20) chk("underflow set", 32'(underflow_o), 32'h1);
      tick(1);
    end
    de_in = 1'b0;
    tick(4);
    clr_status_i = 1'b1;
    tick(1);
    clr_status_i = 1'b0;
    chk("underflow cleared", 32'(underflow_o), 32'h0);
    tick(10);

    for (int k = 0; k < 22; k++)
      chk($sformatf("pixel f%0d v%0d h%0d", tbl[k].fr, tbl[k].v, tbl[k].h),
          32'(cap[tbl[k].fr][tbl[k].v][tbl[k].h]), 32'(tbl[k].exp));
    chk("blank pixels zero", 32'(blank_bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
